// File: rtl/axi_lite_master_cmd.sv
// Single-outstanding AXI4-Lite initiator: turns a cmd/rsp handshake into one
// AW+W+B write or AR+R read at a time, with a sticky handshake-timeout flag.
module axi_lite_master_cmd #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 6,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_write,
  output logic                              err_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TW = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(C_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_RD_A, S_RD_R, S_RSP} state_t;

  state_t          r_state;
  logic            r_cmd_ready;
  logic [AW-1:0]   r_awaddr;
  logic            r_awvalid;
  logic [DW-1:0]   r_wdata;
  logic [SW-1:0]   r_wstrb;
  logic            r_wvalid;
  logic            r_bready;
  logic [AW-1:0]   r_araddr;
  logic            r_arvalid;
  logic            r_rready;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_rdata;
  logic [1:0]      r_rsp_resp;
  logic            r_rsp_write;
  logic            r_err_timeout;
  logic [TW-1:0]   r_tmo_cnt;

  logic w_aw_done;
  logic w_w_done;
  logic w_waiting;

  // A write half is finished once its VALID has dropped or handshakes this edge
  assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
  assign w_w_done  = !r_wvalid  || M_AXI_WREADY;
  assign w_waiting = (r_state == S_WR) || (r_state == S_WR_B) ||
                     (r_state == S_RD_A) || (r_state == S_RD_R);

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b1;
      r_awaddr      <= '0;
      r_awvalid     <= 1'b0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_araddr      <= '0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= 2'b00;
      r_rsp_write   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_tmo_cnt     <= '0;
    end else begin
      // Saturating wait counter; transitions below clear it on state entry
      if (w_waiting) begin
        if (r_tmo_cnt != TMO_MAX) r_tmo_cnt <= r_tmo_cnt + TW'(1);
        if (r_tmo_cnt == TMO_MAX - TW'(1)) r_err_timeout <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_rsp_write <= cmd_write;
            r_tmo_cnt   <= '0;
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_wstrb   <= cmd_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_A;
            end
          end
        end
        S_WR: begin
          if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready  <= 1'b1;
            r_tmo_cnt <= '0;
            r_state   <= S_WR_B;
          end
        end
        S_WR_B: begin
          if (M_AXI_BVALID && r_bready) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= M_AXI_BRESP;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_tmo_cnt   <= '0;
            r_state     <= S_RSP;
          end
        end
        S_RD_A: begin
          if (M_AXI_ARREADY && r_arvalid) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_tmo_cnt <= '0;
            r_state   <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (M_AXI_RVALID && r_rready) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= M_AXI_RDATA;
            r_rsp_resp  <= M_AXI_RRESP;
            r_rsp_valid <= 1'b1;
            r_tmo_cnt   <= '0;
            r_state     <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_tmo_cnt   <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_write     = r_rsp_write;
  assign err_timeout   = r_err_timeout;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// Directed bench for axi_lite_master_cmd against a small register-file AXI4-Lite
// slave whose READY delays and response codes are set per step.
module tb_axi_lite_master_cmd;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, err_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_lite_master_cmd #(
    .C_M_AXI_ADDR_WIDTH(6), .C_M_AXI_DATA_WIDTH(32), .C_TIMEOUT_CYCLES(16)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write), .err_timeout(err_timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  // Slave model: READY rises once VALID has waited *_wait cycles
  int          aw_wait = 0, w_wait = 0, ar_wait = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  int          aw_cnt, w_cnt, ar_cnt;
  int          aw_beats = 0, w_beats = 0;
  logic        got_aw, got_w;
  logic [5:0]  s_awaddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] mem [16];

  assign awready = awvalid && (aw_cnt >= aw_wait);
  assign wready  = wvalid  && (w_cnt  >= w_wait);
  assign arready = arvalid && (ar_cnt >= ar_wait);

  always @(posedge clk) begin
    logic        a_ok, d_ok;
    logic [5:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid  && !wready)  ? w_cnt + 1  : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) begin
        got_aw <= 1'b1; s_awaddr <= awaddr; aw_beats <= aw_beats + 1;
      end
      if (wvalid && wready) begin
        got_w <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; w_beats <= w_beats + 1;
      end
      a_ok = got_aw || (awvalid && awready);
      d_ok = got_w  || (wvalid && wready);
      a    = got_aw ? s_awaddr : awaddr;
      d    = got_w  ? s_wdata  : wdata;
      s    = got_w  ? s_wstrb  : wstrb;
      if (a_ok && d_ok && !bvalid) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mem[a[5:2]][b*8 +: 8] <= d[b*8 +: 8];
        got_aw <= 1'b0; got_w <= 1'b0;
        bvalid <= 1'b1; bresp <= bresp_cfg;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1; rdata <= mem[araddr[5:2]]; rresp <= rresp_cfg;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one command; returns just after the accepting edge
  task automatic issue(input logic w, input logic [5:0] addr, input logic [31:0] d,
                       input logic [3:0] s);
    cmd_write = w; cmd_addr = addr; cmd_wdata = d; cmd_wstrb = s;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  // Edges from the accepting edge up to rsp_valid, bounded
  task automatic wait_rsp(output int lat);
    lat = 1;
    for (int i = 0; i < 100 && !rsp_valid; i++) begin
      step();
      lat++;
    end
    chk("rsp_arrives", 32'(rsp_valid), 32'd1);
  endtask

  task automatic rsp_hs();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  int lat, awb0, wb0;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_prot", {26'd0, awprot, arprot}, 32'd0);
    chk("rst_addr_data", {awaddr, araddr, 20'd0} | wdata, 32'd0);
    rst = 1'b0;
    step();

    // Zero-wait write with partial strobes
    awb0 = aw_beats; wb0 = w_beats;
    issue(1'b1, 6'h14, 32'h0000ABCD, 4'b0011);
    chk("wr_aw_w_valid", {30'd0, awvalid, wvalid}, 32'd3);
    chk("wr_awaddr", 32'(awaddr), 32'h14);
    chk("wr_wdata", wdata, 32'h0000ABCD);
    chk("wr_wstrb", 32'(wstrb), 32'h3);
    chk("wr_cmd_ready_low", 32'(cmd_ready), 32'd0);
    step();
    chk("wr_valids_drop", {30'd0, awvalid, wvalid}, 32'd0);
    chk("wr_bready", 32'(bready), 32'd1);
    chk("wr_no_rsp_yet", 32'(rsp_valid), 32'd0);
    step();
    chk("wr_rsp_valid_lat3", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_fields", {27'd0, rsp_write, rsp_resp, 2'b00}, {27'd0, 1'b1, 2'b00, 2'b00});
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    chk("wr_beats", 32'(((aw_beats - awb0) << 4) | (w_beats - wb0)), 32'h11);
    rsp_hs();
    chk("wr_hs_rsp_drop", 32'(rsp_valid), 32'd0);
    chk("wr_hs_cmd_ready", 32'(cmd_ready), 32'd1);

    // W accepted two cycles ahead of AW
    aw_wait = 2;
    awb0 = aw_beats; wb0 = w_beats;
    issue(1'b1, 6'h08, 32'h12345678, 4'b1111);
    step();
    chk("wfirst_e1", {29'd0, awvalid, wvalid, bready}, 32'b100);
    step();
    chk("wfirst_e2", {29'd0, awvalid, wvalid, bready}, 32'b100);
    step();
    chk("wfirst_e3", {29'd0, awvalid, wvalid, bready}, 32'b001);
    wait_rsp(lat);
    chk("wfirst_beats", 32'(((aw_beats - awb0) << 4) | (w_beats - wb0)), 32'h11);
    rsp_hs();
    aw_wait = 0;

    // Back-to-back writes then reads
    issue(1'b1, 6'h00, 32'h0000AAA0, 4'b1111); wait_rsp(lat); rsp_hs();
    issue(1'b1, 6'h04, 32'h0000AAA1, 4'b1111); wait_rsp(lat); rsp_hs();
    issue(1'b0, 6'h00, 32'h0, 4'h0);
    chk("rd0_arvalid", 32'(arvalid), 32'd1);
    wait_rsp(lat);
    chk("rd0_lat", 32'(lat), 32'd3);
    chk("rd0_data", rsp_rdata, 32'h0000AAA0);
    chk("rd0_fields", {29'd0, rsp_write, rsp_resp}, 32'd0);
    rsp_hs();
    issue(1'b0, 6'h04, 32'h0, 4'h0); wait_rsp(lat);
    chk("rd1_data", rsp_rdata, 32'h0000AAA1);
    chk("rd1_fields", {29'd0, rsp_write, rsp_resp}, 32'd0);
    rsp_hs();

    // SLVERR read with a stalled response consumer
    rresp_cfg = 2'b10;
    issue(1'b0, 6'h14, 32'h0, 4'h0); wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {rsp_valid, cmd_ready, rsp_resp, 28'd0} | {16'd0, rsp_rdata[15:0]},
          {1'b1, 1'b0, 2'b10, 28'd0} | 32'h0000ABCD);
      step();
    end
    rsp_hs();
    chk("stall_released", {30'd0, rsp_valid, cmd_ready}, 32'b01);
    rresp_cfg = 2'b00;

    // DECERR on write passes through without flagging a timeout
    bresp_cfg = 2'b11;
    issue(1'b1, 6'h20, 32'h1, 4'b1111); wait_rsp(lat);
    chk("decerr_resp", 32'(rsp_resp), 32'd3);
    chk("decerr_no_tmo", 32'(err_timeout), 32'd0);
    rsp_hs();
    bresp_cfg = 2'b00;

    // Slow ARREADY trips the timeout at the 16th waiting cycle
    ar_wait = 20;
    issue(1'b0, 6'h08, 32'h0, 4'h0);
    repeat (15) step();
    chk("tmo_before", 32'(err_timeout), 32'd0);
    step();
    chk("tmo_at16", 32'(err_timeout), 32'd1);
    wait_rsp(lat);
    chk("tmo_rd_data", rsp_rdata, 32'h12345678);
    chk("tmo_sticky", 32'(err_timeout), 32'd1);
    rsp_hs();
    ar_wait = 0;

    // Reset while AWVALID is pending
    aw_wait = 50;
    issue(1'b1, 6'h10, 32'hDEAD, 4'b1111);
    chk("prerst_awvalid", 32'(awvalid), 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    aw_wait = 0;
    repeat (3) step();
    chk("postrst_no_rsp", {30'd0, rsp_valid, awvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
